// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller:
// stall bus patterns, FSM state encodings and the multi-cycle counter width.
package pipe_ctrl_pkg;

    typedef logic [5:0] stall_bus_t;
    typedef logic [5:0] mc_count_t;

    // Bit order of the stall bus: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB
    localparam stall_bus_t NoStall   = 6'b000000;
    localparam stall_bus_t StallToID = 6'b000111;
    localparam stall_bus_t StallToEX = 6'b001111;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDone  = 2'd2,
        StFlush = 2'd3
    } state_e;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall generation, multi-cycle EX op sequencing and
// registered flush/redirect. Optional stall statistics with PIPE_CTRL_STATS_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        mc_start,
    input  logic [5:0]  mc_cycles,
    input  logic        mc_cancel,
    input  logic        flush_req,
    input  logic [31:0] flush_pc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
`ifdef PIPE_CTRL_STATS_EN
    output logic [31:0] stall_cycles,
`endif
    output logic        mc_busy,
    output logic        mc_done
);

    state_e      state_q, state_d;
    mc_count_t   cnt_q, cnt_d;
    logic [31:0] new_pc_q, new_pc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            new_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            new_pc_q <= new_pc_d;
        end
    end

    // Flush has priority over everything; it also recaptures the target while held.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        new_pc_d = flush_req ? flush_pc : new_pc_q;
        if (flush_req) begin
            state_d = StFlush;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (mc_start) begin
                        if (mc_cycles != 6'd0) begin
                            state_d = StRun;
                            cnt_d   = mc_cycles;
                        end else begin
                            state_d = StDone;
                        end
                    end
                end
                StRun: begin
                    if (mc_cancel) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_q == 6'd1) begin
                        state_d = StDone;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
                StDone:  state_d = StIdle;
                StFlush: state_d = StIdle;
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // While in reset the registered state is meaningless, so only live requests count.
    always_comb begin
        stall = NoStall;
        if (rst) begin
            if (stallreq_ex || mc_start) begin
                stall = StallToEX;
            end else if (stallreq_id) begin
                stall = StallToID;
            end
        end else if (state_q == StFlush || flush_req) begin
            stall = NoStall;
        end else if (state_q == StRun || (state_q == StIdle && mc_start) || stallreq_ex) begin
            stall = StallToEX;
        end else if (stallreq_id) begin
            stall = StallToID;
        end
    end

    always_comb begin
        mc_busy = (state_q == StRun);
        mc_done = (state_q == StDone);
        flush   = (state_q == StFlush);
        new_pc  = new_pc_q;
    end

`ifdef PIPE_CTRL_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall != NoStall && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule
